tm1637_hex_multi: RTL

//  Parametrised TM1637 hex display controller for 1..6 digits.

---
 rtl/tm1637_hex_multi.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tm1637_hex_multi.sv
// tm1637_hex_multi: 1..6 digit hex display controller for a TM1637 driver.
// A captured display word is turned into the TM1637 command stream
// (data mode, start address, segment bytes, display control) and handed
// byte by byte to the tm1637 serial byte engine, whose pins pass through.

module tm1637 #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       latch,
   input  logic [7:0] byte_in,
   input  logic       stop_bit,
   output logic       busy,
   output logic       scl_en,
   output logic       scl_out,
   output logic       sda_en,
   output logic       sda_out,
   input  logic       sda_in
);
   typedef enum logic [2:0] {E_IDLE, E_START, E_BIT, E_ACK, E_STOP} estate_t;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   estate_t       st;
   logic [DW-1:0] div;
   logic [1:0]    ph;
   logic [2:0]    bitn;
   logic [2:0]    tmo;
   logic [7:0]    sh;
   logic          stop_r, in_txn, scl_low, sda_low;
   logic          tick;

   assign tick    = (div == DW'(CLK_DIV - 1));
   assign scl_en  = scl_low;
   assign scl_out = 1'b0;
   assign sda_en  = sda_low;
   assign sda_out = 1'b0;

   // Bit sequencer: each tick moves only one line, so data edges never look like start/stop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= E_IDLE; div <= '0; ph <= 2'd0; bitn <= 3'd0; tmo <= 3'd0; sh <= 8'h00;
         stop_r <= 1'b0; in_txn <= 1'b0; scl_low <= 1'b0; sda_low <= 1'b0; busy <= 1'b0;
      end else if (st == E_IDLE) begin
         div <= '0; ph <= 2'd0; bitn <= 3'd0;
         if (latch) begin
            sh <= byte_in; stop_r <= stop_bit; busy <= 1'b1;
            st <= in_txn ? E_BIT : E_START;   // no start inside an open transaction
         end
      end else if (!tick) begin
         div <= div + DW'(1);
      end else begin
         div <= '0;
         case (st)
            E_START: begin
               if (ph == 2'd0) begin sda_low <= 1'b1; ph <= 2'd1; end
               else begin scl_low <= 1'b1; ph <= 2'd0; st <= E_BIT; end
            end
            E_BIT: begin
               case (ph)
                  2'd0: begin sda_low <= ~sh[0]; ph <= 2'd1; end
                  2'd1: begin scl_low <= 1'b0; ph <= 2'd2; end
                  default: begin
                     scl_low <= 1'b1; sh <= {1'b0, sh[7:1]}; ph <= 2'd0; bitn <= bitn + 3'd1;
                     if (bitn == 3'd7) st <= E_ACK;
                  end
               endcase
            end
            E_ACK: begin
               case (ph)
                  2'd0: begin sda_low <= 1'b0; tmo <= 3'd0; ph <= 2'd1; end
                  2'd1: begin scl_low <= 1'b0; ph <= 2'd2; end
                  default: begin
                     // a missing ACK only costs a bounded wait, the frame carries on
                     if (!sda_in || tmo == 3'd7) begin
                        scl_low <= 1'b1; ph <= 2'd0;
                        if (stop_r) st <= E_STOP;
                        else begin in_txn <= 1'b1; busy <= 1'b0; st <= E_IDLE; end
                     end else begin
                        tmo <= tmo + 3'd1;
                     end
                  end
               endcase
            end
            E_STOP: begin
               case (ph)
                  2'd0: begin sda_low <= 1'b1; ph <= 2'd1; end
                  2'd1: begin scl_low <= 1'b0; ph <= 2'd2; end
                  default: begin
                     sda_low <= 1'b0; ph <= 2'd0; in_txn <= 1'b0; busy <= 1'b0; st <= E_IDLE;
                  end
               endcase
            end
            default: st <= E_IDLE;
         endcase
      end
   end
endmodule

module tm1637_hex_multi #(
   parameter int DIGITS     = 4,
   parameter int START_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                data_latch,
   input  logic [4*DIGITS-1:0] data_in,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                blank_lz,
   input  logic [2:0]          brightness,
   input  logic                disp_on,
   output logic                busy,
   output logic                done,
   output logic                scl_en,
   output logic                scl_out,
   output logic                sda_en,
   output logic                sda_out,
   input  logic                sda_in
);
   localparam int CW = $clog2(DIGITS) + 1;
   typedef enum logic [2:0] {S_IDLE, S_DATAMODE, S_ADDR, S_DIGIT, S_DISPCTL,
                             S_ISSUE, S_GUARD, S_WAIT} state_t;
   typedef enum logic [1:0] {K_DATAMODE, K_ADDR, K_DIGIT, K_DISPCTL} kind_t;

   state_t              state, state_nxt;
   kind_t               kind;
   logic [CW-1:0]       cnt;
   logic [4*DIGITS-1:0] data_r;
   logic [DIGITS-1:0]   dp_r;
   logic                blank_r, on_r;
   logic [2:0]          bright_r;
   logic [3:0]          nib_r, nib_sel;
   logic                dp_bit_r, blank_bit_r, dp_sel, lz_sel, last_digit;
   logic [DIGITS-1:0]   lz;
   logic [7:0]          tm_byte;
   logic                tm_stop_bit, tm_latch, tm_busy;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0: hex_to_seg = 7'h3F;  4'h1: hex_to_seg = 7'h06;
         4'h2: hex_to_seg = 7'h5B;  4'h3: hex_to_seg = 7'h4F;
         4'h4: hex_to_seg = 7'h66;  4'h5: hex_to_seg = 7'h6D;
         4'h6: hex_to_seg = 7'h7D;  4'h7: hex_to_seg = 7'h07;
         4'h8: hex_to_seg = 7'h7F;  4'h9: hex_to_seg = 7'h6F;
         4'hA: hex_to_seg = 7'h77;  4'hB: hex_to_seg = 7'h7C;
         4'hC: hex_to_seg = 7'h39;  4'hD: hex_to_seg = 7'h5E;
         4'hE: hex_to_seg = 7'h79;  default: hex_to_seg = 7'h71;
      endcase
   endfunction

   assign last_digit = (cnt == CW'(DIGITS - 1));

   // Leading-zero scan (index 0 = leftmost) and selection of the current digit.
   always_comb begin
      logic run;
      run     = blank_r;
      lz      = '0;
      nib_sel = 4'h0;
      dp_sel  = 1'b0;
      lz_sel  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         run     = run & (data_r[4*(DIGITS-1-i) +: 4] == 4'h0);
         lz[i]   = run & (i != DIGITS - 1);
         nib_sel = (cnt == CW'(i)) ? data_r[4*(DIGITS-1-i) +: 4] : nib_sel;
         dp_sel  = (cnt == CW'(i)) ? dp_r[DIGITS-1-i] : dp_sel;
         lz_sel  = (cnt == CW'(i)) ? lz[i] : lz_sel;
      end
   end

   // Next state plus engine handshake; byte/stop depend on registers only, so they are stable in ISSUE.
   always_comb begin
      state_nxt   = state;
      tm_byte     = 8'h00;
      tm_stop_bit = 1'b0;
      case (kind)
         K_DATAMODE: begin tm_byte = 8'h40; tm_stop_bit = 1'b1; end
         K_ADDR:     begin tm_byte = 8'hC0 | 8'(START_ADDR); tm_stop_bit = 1'b0; end
         K_DIGIT:    begin tm_byte = {dp_bit_r, blank_bit_r ? 7'h00 : hex_to_seg(nib_r)};
                           tm_stop_bit = last_digit; end
         default:    begin tm_byte = {4'b1000, on_r, bright_r}; tm_stop_bit = 1'b1; end
      endcase
      tm_latch = (state == S_ISSUE) && !tm_busy;
      done     = (state == S_WAIT) && (kind == K_DISPCTL) && !tm_busy;
      busy     = (state != S_IDLE) && !done;
      case (state)
         S_IDLE:                                 state_nxt = data_latch ? S_DATAMODE : S_IDLE;
         S_DATAMODE, S_ADDR, S_DIGIT, S_DISPCTL: state_nxt = S_ISSUE;
         S_ISSUE:                                state_nxt = tm_busy ? S_ISSUE : S_GUARD;
         S_GUARD:                                state_nxt = S_WAIT;
         S_WAIT: begin
            if (tm_busy) begin
               state_nxt = S_WAIT;
            end else begin
               case (kind)
                  K_DATAMODE: state_nxt = S_ADDR;
                  K_ADDR:     state_nxt = S_DIGIT;
                  K_DIGIT:    state_nxt = last_digit ? S_DISPCTL : S_DIGIT;
                  default:    state_nxt = S_IDLE;
               endcase
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Capture registers, current byte kind, digit counter and registered glyph input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kind <= K_DATAMODE; cnt <= '0; data_r <= '0; dp_r <= '0; blank_r <= 1'b0;
         bright_r <= 3'd0; on_r <= 1'b0; nib_r <= 4'h0; dp_bit_r <= 1'b0; blank_bit_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (data_latch) begin
                  data_r <= data_in; dp_r <= dp_in; blank_r <= blank_lz;
                  bright_r <= brightness; on_r <= disp_on; cnt <= '0;
               end
            end
            S_DATAMODE: kind <= K_DATAMODE;
            S_ADDR:     kind <= K_ADDR;
            S_DIGIT: begin
               kind <= K_DIGIT; nib_r <= nib_sel; dp_bit_r <= dp_sel; blank_bit_r <= lz_sel;
            end
            S_DISPCTL:  kind <= K_DISPCTL;
            S_WAIT: begin
               if (!tm_busy && kind == K_DIGIT && !last_digit) cnt <= cnt + CW'(1);
            end
            default: begin end
         endcase
      end
   end

   tm1637 u_eng (
      .clk(clk), .rst(~rst_n), .latch(tm_latch), .byte_in(tm_byte), .stop_bit(tm_stop_bit),
      .busy(tm_busy), .scl_en(scl_en), .scl_out(scl_out), .sda_en(sda_en), .sda_out(sda_out),
      .sda_in(sda_in)
   );
endmodule
